// File: rtl/text_pixel_compositor.sv
// Text-mode colour stage: attribute blink, hardware cursor and palette lookup
// in a 2-cycle pipeline, with hsync/vsync delayed to stay aligned with RGB.
module text_pixel_compositor #(
    parameter int CHANNEL_BITS     = 1,
    parameter int COLOR_INDEX_BITS = 3,
    parameter int TEXTCOLS_BITS    = 7,
    parameter int TEXTROWS_BITS    = 6,
    parameter int CHARHEIGHT_BITS  = 4,
    parameter int BLINK_FRAMES     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        drawing,
    input  logic [TEXTCOLS_BITS-1:0]    xtext,
    input  logic [TEXTROWS_BITS-1:0]    ytext,
    input  logic [CHARHEIGHT_BITS-1:0]  ychar,
    input  logic                        pixel,
    input  logic [COLOR_INDEX_BITS-1:0] foreground,
    input  logic [COLOR_INDEX_BITS-1:0] background,
    input  logic                        blink,
    input  logic                        cursor_enable,
    input  logic [TEXTCOLS_BITS-1:0]    cursor_x,
    input  logic [TEXTROWS_BITS-1:0]    cursor_y,
    input  logic [CHARHEIGHT_BITS-1:0]  cursor_start,
    input  logic [CHARHEIGHT_BITS-1:0]  cursor_end,
    input  logic                        pal_we,
    input  logic [COLOR_INDEX_BITS-1:0] pal_addr,
    input  logic [3*CHANNEL_BITS-1:0]   pal_data,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic [CHANNEL_BITS-1:0]     red,
    output logic [CHANNEL_BITS-1:0]     green,
    output logic [CHANNEL_BITS-1:0]     blue,
    output logic                        blink_phase,
    output logic                        frame_tick
);
    localparam int PAL_N = 1 << COLOR_INDEX_BITS;
    localparam int PAL_W = 3 * CHANNEL_BITS;
    localparam int CNT_W = $clog2(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_FRAMES / 2);

    // Default entry i: each channel is a replicated bit of the index, {b,g,r}.
    function automatic logic [PAL_W-1:0] pal_default(input int i);
        return {{CHANNEL_BITS{i[2]}}, {CHANNEL_BITS{i[1]}}, {CHANNEL_BITS{i[0]}}};
    endfunction

    logic [PAL_W-1:0]            r_pal [PAL_N];
    logic                        r_vs_prev;
    logic                        r_frame_tick;
    logic                        r_blink_phase;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_s1_draw;
    logic                        r_s1_hs;
    logic                        r_s1_vs;
    logic [COLOR_INDEX_BITS-1:0] r_s1_idx;
    logic [PAL_W-1:0]            r_rgb;
    logic                        r_hs;
    logic                        r_vs;

    logic                        w_fall;
    logic                        w_cursor_phase;
    logic                        w_lit;
    logic                        w_hit;
    logic                        w_sel;
    logic [COLOR_INDEX_BITS-1:0] w_idx;
    logic [PAL_W-1:0]            w_pal_rd;

    assign w_fall         = r_vs_prev & ~vsync_in;
    // Cursor blinks at twice the attribute rate: on for the first half of each period.
    assign w_cursor_phase = (r_cnt < CNT_HALF);
    assign w_lit          = pixel & (~blink | r_blink_phase);
    assign w_hit          = cursor_enable & (xtext == cursor_x) & (ytext == cursor_y)
                          & (cursor_start <= ychar) & (ychar <= cursor_end);
    assign w_sel          = w_lit ^ (w_hit & w_cursor_phase);
    assign w_idx          = w_sel ? foreground : background;
    assign w_pal_rd       = r_pal[r_s1_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_prev     <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_blink_phase <= 1'b1;
            r_cnt         <= '0;
        end else begin
            r_vs_prev    <= vsync_in;
            r_frame_tick <= w_fall;
            if (w_fall) begin
                if (r_cnt == CNT_MAX) begin
                    r_cnt         <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Write lands on the edge; a same-edge read in stage 2 still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) r_pal[i] <= pal_default(i);
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_draw <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_s1_idx  <= '0;
            r_rgb     <= '0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
        end else begin
            r_s1_draw <= drawing;
            r_s1_hs   <= hsync_in;
            r_s1_vs   <= vsync_in;
            r_s1_idx  <= w_idx;
            r_rgb     <= r_s1_draw ? w_pal_rd : '0;
            r_hs      <= r_s1_hs;
            r_vs      <= r_s1_vs;
        end
    end

    assign red         = r_rgb[CHANNEL_BITS-1:0];
    assign green       = r_rgb[2*CHANNEL_BITS-1:CHANNEL_BITS];
    assign blue        = r_rgb[3*CHANNEL_BITS-1:2*CHANNEL_BITS];
    assign hsync_out   = r_hs;
    assign vsync_out   = r_vs;
    assign blink_phase = r_blink_phase;
    assign frame_tick  = r_frame_tick;
endmodule

// File: tb/tb_text_pixel_compositor.sv
// Bench for text_pixel_compositor: a 1-bit/4-frame-blink instance and a
// 4-bit/32-frame instance, checked against a frame-count based reference model.
module tb_text_pixel_compositor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       hsync_in = 0, vsync_in = 0, drawing = 0, pixel = 0, blink = 0;
    logic [6:0] xtext = 0, cursor_x = 0;
    logic [5:0] ytext = 0, cursor_y = 0;
    logic [3:0] ychar = 0, cursor_start = 0, cursor_end = 0;
    logic [2:0] fg = 0, bg = 0, pal_addr = 0, pal_data = 0;
    logic       cursor_enable = 0, pal_we = 0;
    logic        pal_we4 = 1'b0;
    logic [11:0] pal_data4 = 12'h0;

    logic       hs1, vs1, bp1, ft1;
    logic [0:0] r1, g1, b1;
    logic       hs4, vs4, bp4, ft4;
    logic [3:0] r4, g4, b4;

    text_pixel_compositor #(.CHANNEL_BITS(1), .BLINK_FRAMES(4)) u_dut1 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .drawing(drawing), .xtext(xtext), .ytext(ytext), .ychar(ychar), .pixel(pixel),
        .foreground(fg), .background(bg), .blink(blink), .cursor_enable(cursor_enable),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_start(cursor_start),
        .cursor_end(cursor_end), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .hsync_out(hs1), .vsync_out(vs1), .red(r1), .green(g1), .blue(b1),
        .blink_phase(bp1), .frame_tick(ft1));

    text_pixel_compositor #(.CHANNEL_BITS(4), .BLINK_FRAMES(32)) u_dut4 (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .drawing(drawing), .xtext(xtext), .ytext(ytext), .ychar(ychar), .pixel(pixel),
        .foreground(fg), .background(bg), .blink(blink), .cursor_enable(cursor_enable),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_start(cursor_start),
        .cursor_end(cursor_end), .pal_we(pal_we4), .pal_addr(pal_addr), .pal_data(pal_data4),
        .hsync_out(hs4), .vsync_out(vs4), .red(r4), .green(g4), .blue(b4),
        .blink_phase(bp4), .frame_tick(ft4));

    int n_chk = 0, n_fail = 0, n_ticks = 0, n_fall = 0;

    // Reference model: everything derives from the total count of vsync falling edges.
    int         frames;
    logic       prev_vs;
    logic [2:0] m_pal [8];
    logic       s1_draw, s1_hs, s1_vs;
    logic [2:0] s1_idx1, s1_idx4;
    logic [2:0] e_rgb1, e_c4;
    logic       e_hs, e_vs, e_tick;

    function automatic logic bphase(input int f, input int bf);
        return ((f / bf) % 2) == 0;
    endfunction

    function automatic logic [2:0] model_idx(input int f, input int bf);
        logic lit, hit, cph;
        cph = (f % bf) < (bf / 2);
        lit = pixel && (!blink || bphase(f, bf));
        hit = cursor_enable && (xtext == cursor_x) && (ytext == cursor_y)
              && (cursor_start <= ychar) && (ychar <= cursor_end);
        return (lit ^ (hit && cph)) ? fg : bg;
    endfunction

    task automatic model_reset();
        frames = 0; prev_vs = 0;
        for (int i = 0; i < 8; i++) m_pal[i] = i[2:0];
        s1_draw = 0; s1_hs = 0; s1_vs = 0; s1_idx1 = 0; s1_idx4 = 0;
        e_rgb1 = 0; e_c4 = 0; e_hs = 0; e_vs = 0; e_tick = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            e_hs   = s1_hs;
            e_vs   = s1_vs;
            e_rgb1 = s1_draw ? m_pal[s1_idx1] : 3'b000;
            e_c4   = s1_draw ? s1_idx4 : 3'b000;
            if (pal_we) m_pal[pal_addr] = pal_data;
            s1_draw = drawing; s1_hs = hsync_in; s1_vs = vsync_in;
            s1_idx1 = model_idx(frames, 4);
            s1_idx4 = model_idx(frames, 32);
            e_tick  = prev_vs && !vsync_in;
            if (e_tick) frames++;
            prev_vs = vsync_in;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rgb1", {29'd0, b1, g1, r1}, {29'd0, e_rgb1});
        chk("hsync1", {31'd0, hs1}, {31'd0, e_hs});
        chk("vsync1", {31'd0, vs1}, {31'd0, e_vs});
        chk("tick1", {31'd0, ft1}, {31'd0, e_tick});
        chk("bphase1", {31'd0, bp1}, {31'd0, bphase(frames, 4)});
        chk("rgb4", {20'd0, b4, g4, r4},
            {20'd0, {4{e_c4[2]}}, {4{e_c4[1]}}, {4{e_c4[0]}}});
        chk("sync4", {30'd0, hs4, vs4}, {30'd0, e_hs, e_vs});
        chk("tick4", {31'd0, ft4}, {31'd0, e_tick});
        chk("bphase4", {31'd0, bp4}, {31'd0, bphase(frames, 32)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (ft1) n_ticks++;
        check_all();
    endtask

    // Asynchronous reset pulse, asserted and checked away from the clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    task automatic frame();
        vsync_in = 1; tick(); tick();
        vsync_in = 0; n_fall++; tick(); tick(); tick();
    endtask

    typedef struct {
        logic       draw, pix, blk;
        logic [2:0] fgc, bgc;
        logic [2:0] rgb1;   // {b,g,r}
        logic [11:0] rgb4;  // {b,g,r}
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1, 1, 0, 3'd3, 3'd4, 3'b011, 12'h0FF};
        vecs[1] = '{1, 0, 0, 3'd3, 3'd4, 3'b100, 12'hF00};
        vecs[2] = '{0, 1, 0, 3'd3, 3'd4, 3'b000, 12'h000};
        vecs[3] = '{1, 1, 0, 3'd5, 3'd0, 3'b101, 12'hF0F};
        vecs[4] = '{1, 1, 1, 3'd6, 3'd1, 3'b110, 12'hFF0};
        vecs[5] = '{1, 0, 0, 3'd7, 3'd0, 3'b000, 12'h000};
        vecs[6] = '{1, 1, 0, 3'd2, 3'd1, 3'b010, 12'h0F0};
        vecs[7] = '{1, 0, 1, 3'd2, 3'd7, 3'b111, 12'hFFF};

        model_reset();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;

        // Table: steady attributes, blink phase visible, cursor off.
        for (int i = 0; i < 8; i++) begin
            drawing = vecs[i].draw; pixel = vecs[i].pix; blink = vecs[i].blk;
            fg = vecs[i].fgc; bg = vecs[i].bgc;
            tick(); tick();
            chk("tbl_rgb1", {29'd0, b1, g1, r1}, {29'd0, vecs[i].rgb1});
            chk("tbl_rgb4", {20'd0, b4, g4, r4}, {20'd0, vecs[i].rgb4});
        end

        // Sync latency: a single-cycle hsync pulse emerges exactly 2 edges later.
        hsync_in = 1; tick(); chk("hs_lat1", {31'd0, hs1}, 0);
        hsync_in = 0; tick(); chk("hs_lat2", {31'd0, hs1}, 1);
        tick(); chk("hs_lat3", {31'd0, hs1}, 0);

        // Palette write colliding with a read of the same entry.
        drawing = 1; pixel = 1; blink = 0; fg = 3; bg = 4;
        tick();
        pal_we = 1; pal_addr = 3; pal_data = 3'b100;
        tick(); chk("pal_old", {29'd0, b1, g1, r1}, 32'b011);
        pal_we = 0;
        tick(); chk("pal_new", {29'd0, b1, g1, r1}, 32'b100);

        // Reset mid-line: palette defaults restored, first valid colour 2 edges later.
        do_reset();
        tick(); chk("rst_lat1", {29'd0, b1, g1, r1}, 0);
        tick(); chk("rst_lat2", {29'd0, b1, g1, r1}, 32'b011);

        // Attribute blink over 8 frames with BLINK_FRAMES=4.
        blink = 1; n_ticks = 0; n_fall = 0;
        for (int k = 1; k <= 8; k++) begin
            frame();
            if (k == 3) chk("blink_f3", {31'd0, bp1}, 1);
            if (k == 4) begin
                chk("blink_f4", {31'd0, bp1}, 0);
                chk("blink_bg", {29'd0, b1, g1, r1}, 32'b100);
            end
            if (k == 8) chk("blink_f8", {31'd0, bp1}, 1);
        end
        chk("tick_count", n_ticks, n_fall);
        blink = 0;

        // Cursor at (5,2), rows 12..13; frames=8 so the cursor phase is on.
        pixel = 0; cursor_enable = 1; cursor_x = 5; cursor_y = 2;
        cursor_start = 12; cursor_end = 13;
        for (int x = 4; x <= 6; x++)
            for (int y = 1; y <= 3; y++)
                for (int c = 11; c <= 14; c++) begin
                    xtext = 7'(x); ytext = 6'(y); ychar = 4'(c);
                    tick();
                end
        xtext = 5; ytext = 2; ychar = 13;
        tick(); tick(); chk("cur_on", {29'd0, b1, g1, r1}, 32'b011);
        cursor_start = 13; cursor_end = 12;
        tick(); tick(); chk("cur_inv", {29'd0, b1, g1, r1}, 32'b100);
        cursor_start = 12; cursor_end = 13;
        frame(); frame();
        tick(); tick(); chk("cur_off", {29'd0, b1, g1, r1}, 32'b100);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            drawing  = ($urandom_range(0, 7) != 0);
            pixel    = $urandom_range(0, 1);
            blink    = $urandom_range(0, 1);
            fg       = 3'($urandom_range(0, 7));
            bg       = 3'($urandom_range(0, 7));
            hsync_in = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
            cursor_enable = ($urandom_range(0, 3) != 0);
            cursor_x = 7'($urandom_range(3, 5));
            cursor_y = 6'($urandom_range(1, 2));
            cursor_start = 4'($urandom_range(0, 15));
            cursor_end   = 4'($urandom_range(0, 15));
            xtext = 7'($urandom_range(3, 5));
            ytext = 6'($urandom_range(1, 2));
            ychar = 4'($urandom_range(0, 15));
            pal_we   = ($urandom_range(0, 7) == 0);
            pal_addr = 3'($urandom_range(0, 7));
            pal_data = 3'($urandom_range(0, 7));
            tick();
        end
        pal_we = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
